// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file read path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

    // Default configuration of the 4x4-bit register file.
    localparam int DEF_WIDTH = 4;
    localparam int DEF_NREGS = 4;
    localparam int DEF_AW    = (DEF_NREGS > 1) ? $clog2(DEF_NREGS) : 1;

    // Occupancy of the fetch buffer: output stage, then skid entry.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } fetch_state_t;

    // Held operand request in the default configuration. Blocks built with
    // non-default WIDTH/NREGS declare the same layout with their own widths.
    typedef struct packed {
        logic [DEF_AW-1:0]    addr_a;
        logic [DEF_AW-1:0]    addr_b;
        logic [DEF_WIDTH-1:0] data_a;
        logic [DEF_WIDTH-1:0] data_b;
    } rf_entry_t;

    // Register index width; a single-register file still needs one address bit.
    function automatic int addr_width(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/regfile_operand_fetch_forward.sv
// Per-operand forwarding mux: picks the value a register holds after this edge.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module operand_forward
    import regfile_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NREGS   = DEF_NREGS,
    parameter int AW      = addr_width(NREGS),
    parameter int LANES   = 1,
    // 1: capture a fresh read from rf_flat; 0: refresh an already-held value.
    parameter bit CAPTURE = 1'b0
) (
    input  logic [LANES-1:0][AW-1:0]    addr,
    input  logic [NREGS*WIDTH-1:0]      rf_flat,
    input  logic [NREGS-1:0]            wr_en,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic [LANES-1:0][WIDTH-1:0] cur_data,
    output logic [LANES-1:0][WIDTH-1:0] next_data
);

    logic [LANES-1:0][WIDTH-1:0] rd_word;
    logic [LANES-1:0]            wr_hit;

    // Decode each lane's register: its current contents and whether this edge writes it.
    always_comb begin
        rd_word = '0;
        wr_hit  = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int i = 0; i < NREGS; i++) begin
                if (addr[l] == AW'(i)) begin
                    rd_word[l] = rf_flat[i*WIDTH +: WIDTH];
                    wr_hit[l]  = wr_en[i];
                end
            end
        end
    end

    // A same-edge write always wins; otherwise read the file or keep the held value.
    always_comb begin
        next_data = '0;
        for (int l = 0; l < LANES; l++) begin
            if (wr_hit[l]) begin
                next_data[l] = wr_data;
            end else if (CAPTURE) begin
                next_data[l] = rd_word[l];
            end else begin
                next_data[l] = cur_data[l];
            end
        end
    end

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand fetch: reads two source registers per request, forwards same-edge writes.
// Latency: response valid the cycle after acceptance; one request per cycle sustained.
// Backpressure: two-entry buffer (output stage + skid); req_ready drops once the skid fills.
module regfile_operand_fetch
    import regfile_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int NREGS = DEF_NREGS,
    localparam int AW    = addr_width(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREGS*WIDTH-1:0] rf_flat,
    input  logic [NREGS-1:0]       wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [AW-1:0]          req_a,
    input  logic [AW-1:0]          req_b,
    output logic                   op_valid,
    input  logic                   op_ready,
    output logic [WIDTH-1:0]       op_a,
    output logic [WIDTH-1:0]       op_b
);

    typedef struct packed {
        logic [AW-1:0]    addr_a;
        logic [AW-1:0]    addr_b;
        logic [WIDTH-1:0] data_a;
        logic [WIDTH-1:0] data_b;
    } entry_t;

    fetch_state_t state;
    entry_t       out_q;
    entry_t       skid_q;
    logic         op_valid_q;

    logic accept;
    logic deliver;

    logic [WIDTH-1:0]      cap_a;
    logic [WIDTH-1:0]      cap_b;
    logic [1:0][WIDTH-1:0] out_ref;
    logic [1:0][WIDTH-1:0] skid_ref;

    entry_t new_entry;
    entry_t out_held;
    entry_t skid_held;

    assign req_ready = !reset && (state != TWO);
    // Reset discards held entries immediately, so nothing can be delivered under reset.
    assign op_valid  = op_valid_q && !reset;
    assign accept    = req_valid && req_ready;
    assign deliver   = op_valid && op_ready;

    assign op_a = out_q.data_a;
    assign op_b = out_q.data_b;

    operand_forward #(
        .WIDTH(WIDTH), .NREGS(NREGS), .AW(AW), .LANES(1), .CAPTURE(1'b1)
    ) u_capture_a (
        .addr      (req_a),
        .rf_flat   (rf_flat),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .cur_data  ('0),
        .next_data (cap_a)
    );

    operand_forward #(
        .WIDTH(WIDTH), .NREGS(NREGS), .AW(AW), .LANES(1), .CAPTURE(1'b1)
    ) u_capture_b (
        .addr      (req_b),
        .rf_flat   (rf_flat),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .cur_data  ('0),
        .next_data (cap_b)
    );

    operand_forward #(
        .WIDTH(WIDTH), .NREGS(NREGS), .AW(AW), .LANES(2), .CAPTURE(1'b0)
    ) u_refresh_main (
        .addr      ({out_q.addr_a, out_q.addr_b}),
        .rf_flat   (rf_flat),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .cur_data  ({out_q.data_a, out_q.data_b}),
        .next_data (out_ref)
    );

    operand_forward #(
        .WIDTH(WIDTH), .NREGS(NREGS), .AW(AW), .LANES(2), .CAPTURE(1'b0)
    ) u_refresh_skid (
        .addr      ({skid_q.addr_a, skid_q.addr_b}),
        .rf_flat   (rf_flat),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .cur_data  ({skid_q.data_a, skid_q.data_b}),
        .next_data (skid_ref)
    );

    // Assemble the freshly captured request and the refreshed copies of both held entries.
    always_comb begin
        new_entry        = '0;
        new_entry.addr_a = req_a;
        new_entry.addr_b = req_b;
        new_entry.data_a = cap_a;
        new_entry.data_b = cap_b;

        out_held         = out_q;
        out_held.data_a  = out_ref[1];
        out_held.data_b  = out_ref[0];

        skid_held        = skid_q;
        skid_held.data_a = skid_ref[1];
        skid_held.data_b = skid_ref[0];
    end

    // Occupancy FSM: loads, refreshes and shifts the two entries; op_valid registered alongside.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            out_q      <= '0;
            skid_q     <= '0;
            op_valid_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_q      <= new_entry;
                        state      <= ONE;
                        op_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        out_q <= new_entry;
                    end else if (accept) begin
                        out_q  <= out_held;
                        skid_q <= new_entry;
                        state  <= TWO;
                    end else if (deliver) begin
                        state      <= EMPTY;
                        op_valid_q <= 1'b0;
                    end else begin
                        out_q <= out_held;
                    end
                end
                TWO: begin
                    if (deliver) begin
                        // The skid entry must see this edge's writes as it moves up.
                        out_q <= skid_held;
                        state <= ONE;
                    end else begin
                        out_q  <= out_held;
                        skid_q <= skid_held;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    op_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
